axis_frame_src: RTL
===================

# axis_frame_src

Registered AXI4-Stream video frame transmitter: the master-side producer of the same pixel stream (tdata/tuser/tlast/tvalid/tready) that the stream relays and scalers consume. Generates whole frames of configurable width × height with start-of-frame on tuser and end-of-line on tlast, and honours downstream back-pressure. Drives bring-up and regression of every downstream stream block in place of the camera path.

## Interface
- C_PIXEL_WIDTH, 8, tdata width in bits.
- C_IMG_WBITS, 12, width of img_width and of the column counter.
- C_IMG_HBITS, 12, width of img_height and of the row counter.
- clk  in  1  clock; all logic rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  level; frames are generated while high.
- img_width  in  C_IMG_WBITS  pixels per line; latched at frame start.
- img_height  in  C_IMG_HBITS  lines per frame; latched at frame start.
- pattern  in  2  data pattern select; latched at frame start.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tdata  out  C_PIXEL_WIDTH  pixel value.
- m_axis_tuser  out  1  high on pixel (0,0) only.
- m_axis_tlast  out  1  high on last pixel of every line.
- m_axis_tready  in  1  downstream accept.
- busy  out  1  high from frame start until last pixel accepted.
- frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted.
- frame_cnt  out  8  completed-frame count, wraps 255→0.

## Operation
- States: IDLE, ACTIVE. Reset enters IDLE.
- IDLE: if enable=1 and img_width≠0 and img_height≠0, latch width, height, pattern; x=0, y=0; go ACTIVE. Otherwise stay IDLE. Zero width or height never starts a frame.
- ACTIVE: m_axis_tvalid=1 continuously. Handshake = tvalid && tready.
- On handshake: if x≠W-1, x++; else x=0 and (if y≠H-1, y++; else frame end).
- Frame end: go IDLE, pulse frame_done, frame_cnt++ (mod 256), tvalid drops next cycle.
- Exactly one IDLE cycle between back-to-back frames; enable re-sampled there.
- enable falling mid-frame does not abort: frame completes fully (tvalid must not drop before handshake).
- tuser = (x==0 && y==0); tlast = (x==W-1). W=1 makes every pixel tlast; W=H=1 makes single pixel both tuser and tlast.
- tdata (truncated to C_PIXEL_WIDTH, modulo arithmetic):
  - pattern 0: x; pattern 1: y; pattern 2: x+y; pattern 3: frame_cnt value at frame start.
- img_width/img_height/pattern changes during ACTIVE have no effect until next frame start.
- busy = (state==ACTIVE).

## Timing
- Reset (async assert): m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, busy=0, frame_done=0, frame_cnt=0, state IDLE, x=y=0. Reset mid-frame abandons the frame immediately; no partial completion.
- All outputs registered; no combinational path from m_axis_tready or enable to any output.
- enable high in IDLE at edge N → tvalid=1, tuser=1, busy=1 after edge N+1... precisely: visible in the cycle following edge N.
- With tready held 1: one pixel per cycle; frame occupies W·H cycles, then 1 IDLE cycle; throughput W·H/(W·H+1).
- tvalid && !tready: tdata, tuser, tlast held stable until the handshake cycle.
- Next pixel's tdata/tuser/tlast presented in the cycle after each handshake.
- frame_done asserted the cycle after the final handshake, concurrent with busy=0 and tvalid=0.

## Test plan
- W=4, H=3, pattern 0, tready=1, enable=1: 12 beats, tdata 0,1,2,3 per line, tuser on beat 1 only, tlast on beats 4/8/12, frame_done one cycle later, 1-cycle gap, second frame starts with tuser.
- Same config, tready random 50%: sequence identical to above; tdata/tuser/tlast never change while tvalid&&!tready; tvalid never drops mid-frame.
- W=1, H=1, pattern 3, 3 frames: each beat has tuser=1 and tlast=1, tdata 0,1,2; frame_cnt ends at 3.
- enable dropped after beat 5 of 4×3 frame: remaining 7 beats delivered, frame_done pulses, then tvalid stays 0.
- img_width=0 with enable=1: tvalid, busy remain 0 indefinitely; then set width=2, H=2 → frame starts next cycle.
- resetn asserted on beat 6 of 4×3 frame with tready=0: all outputs 0 immediately; after release with enable=1, new frame starts at pixel (0,0) with tuser=1, frame_cnt=0.

Source files
------------

// File: rtl/axis_frame_src.sv
// AXI4-Stream video frame source: emits width x height frames with tuser on the
// first pixel and tlast on each line end, fully registered and back-pressure aware.
module axis_frame_src #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [C_IMG_WBITS-1:0]   img_width,
  input  logic [C_IMG_HBITS-1:0]   img_height,
  input  logic [1:0]               pattern,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state_reg, state_next;
  logic [C_IMG_WBITS-1:0]   x_reg, x_next, w_reg, w_next, w_last;
  logic [C_IMG_HBITS-1:0]   y_reg, y_next, h_reg, h_next, h_last;
  logic [1:0]               pat_reg, pat_next;
  logic [7:0]               base_reg, base_next;
  logic [7:0]               cnt_reg, cnt_next;
  logic                     tvalid_reg, tvalid_next;
  logic [C_PIXEL_WIDTH-1:0] tdata_reg, tdata_next;
  logic                     tuser_reg, tuser_next;
  logic                     tlast_reg, tlast_next;
  logic                     done_reg, done_next;
  logic                     frame_end;

  // Truncating each operand first gives the same result as truncating the sum.
  function automatic logic [C_PIXEL_WIDTH-1:0] pixel_value(
    input logic [C_IMG_WBITS-1:0] x,
    input logic [C_IMG_HBITS-1:0] y,
    input logic [1:0]             pat,
    input logic [7:0]             base
  );
    logic [C_PIXEL_WIDTH-1:0] v;
    case (pat)
      2'd0:    v = C_PIXEL_WIDTH'(x);
      2'd1:    v = C_PIXEL_WIDTH'(y);
      2'd2:    v = C_PIXEL_WIDTH'(x) + C_PIXEL_WIDTH'(y);
      default: v = C_PIXEL_WIDTH'(base);
    endcase
    return v;
  endfunction

  assign w_last = w_reg - C_IMG_WBITS'(1);
  assign h_last = h_reg - C_IMG_HBITS'(1);

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    w_next      = w_reg;
    h_next      = h_reg;
    pat_next    = pat_reg;
    base_next   = base_reg;
    cnt_next    = cnt_reg;
    tvalid_next = tvalid_reg;
    tdata_next  = tdata_reg;
    tuser_next  = tuser_reg;
    tlast_next  = tlast_reg;
    done_next   = 1'b0;
    frame_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && (img_width != '0) && (img_height != '0)) begin
          state_next  = ACTIVE;
          w_next      = img_width;
          h_next      = img_height;
          pat_next    = pattern;
          base_next   = cnt_reg;
          x_next      = '0;
          y_next      = '0;
          tvalid_next = 1'b1;
          tdata_next  = pixel_value('0, '0, pattern, cnt_reg);
          tuser_next  = 1'b1;
          tlast_next  = (img_width == C_IMG_WBITS'(1));
        end
      end
      ACTIVE: begin
        if (m_axis_tready) begin
          if (x_reg != w_last) begin
            x_next = x_reg + C_IMG_WBITS'(1);
          end else begin
            x_next = '0;
            if (y_reg != h_last) y_next = y_reg + C_IMG_HBITS'(1);
            else                 frame_end = 1'b1;
          end
          if (frame_end) begin
            state_next  = IDLE;
            x_next      = '0;
            y_next      = '0;
            tvalid_next = 1'b0;
            tdata_next  = '0;
            tuser_next  = 1'b0;
            tlast_next  = 1'b0;
            done_next   = 1'b1;
            cnt_next    = cnt_reg + 8'd1;
          end else begin
            // Pixel (0,0) is only ever presented at frame start, never after a handshake.
            tdata_next = pixel_value(x_next, y_next, pat_reg, base_reg);
            tuser_next = 1'b0;
            tlast_next = (x_next == w_last);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      pat_reg    <= '0;
      base_reg   <= '0;
      cnt_reg    <= '0;
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tuser_reg  <= 1'b0;
      tlast_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      w_reg      <= w_next;
      h_reg      <= h_next;
      pat_reg    <= pat_next;
      base_reg   <= base_next;
      cnt_reg    <= cnt_next;
      tvalid_reg <= tvalid_next;
      tdata_reg  <= tdata_next;
      tuser_reg  <= tuser_next;
      tlast_reg  <= tlast_next;
      done_reg   <= done_next;
    end
  end

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = (state_reg == ACTIVE);
  assign frame_done    = done_reg;
  assign frame_cnt     = cnt_reg;

endmodule
